mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_pkg.sv | 38 +++
 rtl/mem_bus_responder_ram.sv | 44 ++++
 rtl/mem_bus_responder.sv | 193 +++++++++++++++++++
 tb/tb_mem_bus_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
//   Shared definitions for the mem_bus_responder slice.
//   - BUS_ADDR_W / BUS_DATA_W : word-address and data widths of the bus.
//   - WAIT_CNT_W              : width of the wait-state counter (0..15).
//   - bus_state_e             : responder FSM states.
//   - addr_in_range()         : checks an address against a served window.
// -----------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int BUS_ADDR_W = 27;
  localparam int BUS_DATA_W = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  // True when addr lies in [base, base+depth-1]. The comparison is done one bit
  // wider than the bus so a window that reaches the top of the address space
  // does not wrap around.
  function automatic logic addr_in_range(
    input logic [BUS_ADDR_W-1:0] addr,
    input logic [BUS_ADDR_W-1:0] base,
    input logic [BUS_ADDR_W:0]   depth
  );
    logic [BUS_ADDR_W:0] a;
    logic [BUS_ADDR_W:0] lo;
    logic [BUS_ADDR_W:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + depth;
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/mem_bus_responder_ram.sv
// -----------------------------------------------------------------------------
// mem_bus_responder_ram
//   Single-port word array backing the bus responder. Synchronous read,
//   write-enable, no reset on contents. The read register only updates on a
//   read access, so a write leaves the last read word on rdata.
//
//   Ports:
//     clk    in   clock
//     en     in   access enable for this cycle
//     we     in   1 = write wdata to addr, 0 = read addr into rdata
//     addr   in   word index, $clog2(DEPTH) bits
//     wdata  in   write data
//     rdata  out  registered read data (holds until the next read)
// -----------------------------------------------------------------------------
module mem_bus_responder_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [BUS_DATA_W-1:0] wdata,
  output logic [BUS_DATA_W-1:0] rdata
);

  logic [BUS_DATA_W-1:0] mem [DEPTH];
  logic [BUS_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
//   Simple memory-mapped slave: accepts a one-cycle request pulse, waits
//   WAIT_STATES cycles, then completes the access against an internal word
//   array and pulses bus_done for one cycle. Back-to-back requests are taken
//   directly from DONE with no gap cycle; requests arriving while WAIT is in
//   progress are ignored.
//
//   Optional feature: define MEM_BUS_RESPONDER_ERR_EN to enable the sticky
//   bus_err flag (out-of-window access, or a request during WAIT). With it
//   enabled, out-of-window reads return 0 and out-of-window writes are dropped;
//   without it, bus_err is 0 and addresses alias modulo DEPTH.
//
//   Parameters:
//     DEPTH        words in the array (power of two, >= 2)
//     BASE_ADDR    first word address served
//     WAIT_STATES  extra response cycles, 0..15
//
//   Ports:
//     clk        in   clock, all state changes on rising edge
//     reset      in   asynchronous active-low reset
//     bus_addr   in   word address, sampled with bus_start
//     bus_data   in   write data, sampled with bus_start
//     bus_we     in   1 = write, 0 = read, sampled with bus_start
//     bus_start  in   one-cycle request pulse
//     bus_q      out  read data, valid while bus_done is high, then held
//     bus_done   out  one-cycle completion pulse
//     bus_err    out  sticky error flag
// -----------------------------------------------------------------------------
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int                    DEPTH       = 1024,
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 27'h0000000,
  parameter int                    WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_ADDR_W-1:0] bus_addr,
  input  logic [BUS_DATA_W-1:0] bus_data,
  input  logic                  bus_we,
  input  logic                  bus_start,
  output logic [BUS_DATA_W-1:0] bus_q,
  output logic                  bus_done,
  output logic                  bus_err
);

  localparam int IDX_W = $clog2(DEPTH);
  // With no wait states the request completes on its acceptance edge, so the
  // access must be taken from the bus rather than from the request registers.
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  bus_state_e state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  oor_q, oor_d;     // latched request is out of window
  logic                  q_sel_q, q_sel_d; // 1: bus_q shows array read data
  logic                  err_q, err_d;

  logic                  accept;
  logic                  req_oor;
  logic                  enter_done;
  logic                  cmp_we;
  logic                  cmp_oor;
  logic [BUS_ADDR_W-1:0] cmp_addr;
  logic [BUS_DATA_W-1:0] cmp_data;
  logic                  ram_en;
  logic [IDX_W-1:0]      ram_idx;
  logic [BUS_DATA_W-1:0] ram_rdata;

  assign accept = bus_start && ((state_q == IDLE) || (state_q == DONE));

`ifdef MEM_BUS_RESPONDER_ERR_EN
  assign req_oor = !addr_in_range(bus_addr, BASE_ADDR, (BUS_ADDR_W+1)'(DEPTH));
`else
  assign req_oor = 1'b0;
`endif

  // Next-state and request-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    oor_d   = oor_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (NO_WAIT) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      addr_d = bus_addr;
      data_d = bus_data;
      we_d   = bus_we;
      oor_d  = req_oor;
    end
  end

  // The access completes on the edge that enters DONE: writes commit and reads
  // capture on that same edge.
  assign enter_done = (state_d == DONE);
  assign cmp_we     = NO_WAIT ? bus_we   : we_q;
  assign cmp_addr   = NO_WAIT ? bus_addr : addr_q;
  assign cmp_data   = NO_WAIT ? bus_data : data_q;
  assign cmp_oor    = NO_WAIT ? req_oor  : oor_q;
  assign ram_idx    = IDX_W'(cmp_addr - BASE_ADDR);

  // The array has no reset, so while reset is held the access enable is forced
  // off; otherwise a zero-wait request presented during reset could commit.
  assign ram_en = enter_done && !cmp_oor && reset;

  // bus_q source select and sticky error.
  always_comb begin
    q_sel_d = q_sel_q;
    err_d   = err_q;
    if (enter_done && !cmp_we) begin
      q_sel_d = !cmp_oor;
    end
`ifdef MEM_BUS_RESPONDER_ERR_EN
    if ((accept && req_oor) || (bus_start && (state_q == WAIT))) begin
      err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      q_sel_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      q_sel_q <= q_sel_d;
      err_q   <= err_d;
    end
  end

  mem_bus_responder_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cmp_we),
    .addr  (ram_idx),
    .wdata (cmp_data),
    .rdata (ram_rdata)
  );

  // bus_q reads as zero after reset and after an out-of-window read; the RAM
  // read register itself cannot be cleared.
  assign bus_q    = q_sel_q ? ram_rdata : '0;
  assign bus_done = (state_q == DONE);
  assign bus_err  = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

  localparam int DEPTH = 16;
  localparam int WA    = 2;
`ifdef MEM_BUS_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [26:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_we = 1'b0, b_we = 1'b0, a_start = 1'b0, b_start = 1'b0;
  logic [31:0] a_q, b_q;
  logic        a_done, b_done, a_err, b_err;

  int vecs = 0;
  int miscompares = 0;

  // Reference model: word arrays, last read value, sticky error.
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] q_a = '0, q_b = '0;
  bit          err_a = 1'b0, err_b = 1'b0;

  always #5 clk = ~clk;

  mem_bus_responder #(.DEPTH(DEPTH), .BASE_ADDR(27'h0), .WAIT_STATES(WA)) u_dut_a (
    .clk(clk), .reset(reset), .bus_addr(a_addr), .bus_data(a_data), .bus_we(a_we),
    .bus_start(a_start), .bus_q(a_q), .bus_done(a_done), .bus_err(a_err)
  );

  mem_bus_responder #(.DEPTH(DEPTH), .BASE_ADDR(27'h0), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset), .bus_addr(b_addr), .bus_data(b_data), .bus_we(b_we),
    .bus_start(b_start), .bus_q(b_q), .bus_done(b_done), .bus_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oor(input logic [26:0] addr);
    return ERR_EN && (int'(addr) >= DEPTH);
  endfunction

  function automatic int idx_of(input logic [26:0] addr);
    return int'(addr) % DEPTH;
  endfunction

  // One request on instance A (WAIT_STATES=2), called just after a rising edge.
  // poke=1 fires a stray write request during the first WAIT cycle.
  task automatic txn_a(input logic we, input logic [26:0] addr, input logic [31:0] data,
                       input bit poke);
    a_we = we; a_addr = addr; a_data = data; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    if (is_oor(addr)) err_a = 1'b1;
    for (int n = 1; n <= WA; n++) begin
      chk("a_done_in_wait", 32'(a_done), 32'd0);
      chk("a_q_in_wait", a_q, q_a);
      if (poke && n == 1) begin
        a_start = 1'b1; a_we = 1'b1; a_addr = 27'd3; a_data = ~mem_a[3];
        if (ERR_EN) err_a = 1'b1;
      end
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    if (!is_oor(addr)) begin
      if (we) mem_a[idx_of(addr)] = data;
      else    q_a = mem_a[idx_of(addr)];
    end else if (!we) begin
      q_a = '0;
    end
    chk("a_done", 32'(a_done), 32'd1);
    chk(we ? "a_q_after_write" : "a_read_q", a_q, q_a);
    chk("a_err", 32'(a_err), 32'(err_a));
    @(posedge clk); #1;
    chk("a_done_fall", 32'(a_done), 32'd0);
    chk("a_q_hold", a_q, q_a);
  endtask

  // One back-to-back step on instance B (WAIT_STATES=0): bus_start stays high.
  task automatic step_b(input logic we, input logic [26:0] addr, input logic [31:0] data);
    b_we = we; b_addr = addr; b_data = data; b_start = 1'b1;
    @(posedge clk); #1;
    if (is_oor(addr)) begin
      err_b = 1'b1;
      if (!we) q_b = '0;
    end else if (we) begin
      mem_b[idx_of(addr)] = data;
    end else begin
      q_b = mem_b[idx_of(addr)];
    end
    chk("b_done", 32'(b_done), 32'd1);
    chk(we ? "b_q_after_write" : "b_read_q", b_q, q_b);
    chk("b_err", 32'(b_err), 32'(err_b));
  endtask

  task automatic idle_b();
    b_start = 1'b0;
    @(posedge clk); #1;
    chk("b_done_fall", 32'(b_done), 32'd0);
    chk("b_q_hold", b_q, q_b);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [26:0] ra;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_q", a_q, 32'd0);
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_b_done", 32'(b_done), 32'd0);
    chk("rst_b_q", b_q, 32'd0);
    chk("rst_b_err", 32'(b_err), 32'd0);

    // Release reset and issue a request in the very first cycle after it.
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rnd = $urandom;
      txn_a(1'b1, 27'(i), rnd, 1'b0);
    end

    // Write then read back a known word.
    txn_a(1'b1, 27'd5, 32'hDEADBEEF, 1'b0);
    txn_a(1'b0, 27'd5, 32'h0, 1'b0);
    chk("a_read5_beef", a_q, 32'hDEADBEEF);

    // Randomised mix, including addresses beyond the window.
    repeat (24) begin
      ra  = 27'($urandom_range(0, 2 * DEPTH - 1));
      rnd = $urandom;
      txn_a(1'($urandom_range(0, 1)), ra, rnd, 1'b0);
    end

    // Top word, all ones; word 0 must be untouched.
    txn_a(1'b1, 27'(DEPTH - 1), 32'hFFFFFFFF, 1'b0);
    txn_a(1'b0, 27'(DEPTH - 1), 32'h0, 1'b0);
    chk("a_top_word", a_q, 32'hFFFFFFFF);
    txn_a(1'b0, 27'd0, 32'h0, 1'b0);

    // Stray request during WAIT: one completion only, stray write dropped.
    rnd = $urandom;
    txn_a(1'b1, 27'd9, rnd, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("a_no_extra_done", 32'(a_done), 32'd0);
    end
    chk("a_err_after_poke", 32'(a_err), 32'(ERR_EN));
    txn_a(1'b0, 27'd3, 32'h0, 1'b0);

    // Just past the window.
    txn_a(1'b0, 27'(DEPTH), 32'h0, 1'b0);

    // Reset one cycle after a write is accepted: no completion, no commit.
    a_we = 1'b1; a_addr = 27'd7; a_data = 32'h12345678; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_done", 32'(a_done), 32'd0);
    chk("mid_rst_q", a_q, 32'd0);
    chk("mid_rst_err", 32'(a_err), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", 32'(a_done), 32'd0);
    end
    reset = 1'b1;
    q_a = '0; err_a = 1'b0; q_b = '0; err_b = 1'b0;
    txn_a(1'b0, 27'd7, 32'h0, 1'b0);

    // Instance B: fill back-to-back, then a 4-cycle burst of reads.
    for (int i = 0; i < DEPTH; i++) begin
      rnd = $urandom;
      step_b(1'b1, 27'(i), rnd);
    end
    idle_b();
    for (int i = 0; i < 4; i++) step_b(1'b0, 27'(i), 32'h0);
    idle_b();

    // Randomised back-to-back stream with occasional gaps.
    repeat (30) begin
      ra  = 27'($urandom_range(0, 2 * DEPTH - 1));
      rnd = $urandom;
      step_b(1'($urandom_range(0, 1)), ra, rnd);
      if ($urandom_range(0, 3) == 0) idle_b();
    end
    idle_b();

    // Alias / out-of-window read on B, then a write must not disturb bus_q.
    step_b(1'b0, 27'(DEPTH), 32'h0);
    rnd = $urandom;
    step_b(1'b1, 27'd2, rnd);
    idle_b();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
